// File: rtl/cfg_chain_pkg.sv
// Shared types and elaboration helpers for the configuration-chain loader.
// Chain geometry is derived here so every file agrees on length and word count.
package cfg_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_FIN  = 2'd3
    } chain_state_e;

    localparam logic MODE_WR = 1'b0;
    localparam logic MODE_RD = 1'b1;

    function automatic int chain_len(input int num_cells, input int cell_bits);
        return num_cells * cell_bits;
    endfunction

    function automatic int chain_nwords(input int len, input int word_w);
        return (word_w > 0) ? (len / word_w) : 0;
    endfunction

    // Words need at least two bits so the shift slices stay legal.
    function automatic bit chain_cfg_ok(input int len, input int word_w);
        return (word_w >= 2) && (len > 0) && ((len % word_w) == 0);
    endfunction

endpackage

// File: rtl/cfg_word_serdes.sv
// One word-wide shift register used both to serialise write words onto the
// chain and to assemble readback words from it, in either bit order.
module cfg_word_serdes
    import cfg_chain_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter int BCW       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              shift,
    input  logic              ser_in,
    input  logic [BCW-1:0]    bit_cnt,
    output logic              ser_out,
    output logic [WORD_W-1:0] par_next,
    output logic              last_bit
);

    localparam logic [BCW-1:0] BIT_LAST = BCW'(WORD_W - 1);

    logic [WORD_W-1:0] sr_q;
    logic [WORD_W-1:0] shifted;

    // The same shift direction serves both jobs: the first bit out is the
    // first bit in, so a captured word lands in the same order it was written.
    always_comb begin
        shifted = sr_q;
        if (MSB_FIRST) begin
            shifted = {sr_q[WORD_W-2:0], ser_in};
        end else begin
            shifted = {ser_in, sr_q[WORD_W-1:1]};
        end
    end

    assign ser_out  = MSB_FIRST ? sr_q[WORD_W-1] : sr_q[0];
    assign par_next = shifted;
    assign last_bit = shift && (bit_cnt == BIT_LAST);

    // A load coinciding with the final shift of the previous word wins,
    // which is what lets back-to-back words stream without a bubble.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= load_data;
        end else if (shift) begin
            sr_q <= shifted;
        end
    end

endmodule

// File: rtl/cfg_chain_loader.sv
// Head-of-row controller for a daisy-chained configuration row: streams write
// words onto the chain, or recirculates it non-destructively for readback.
module cfg_chain_loader
    import cfg_chain_pkg::*;
#(
    parameter int NUM_CELLS = 8,
    parameter int CELL_BITS = 32,
    parameter int WORD_W    = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              prog_clk,
    input  logic              prog_rst,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              chain_dout,
    output logic              chain_en,
    input  logic              chain_din,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [1:0]        state_dbg
);

    localparam int CHAIN_LEN = chain_len(NUM_CELLS, CELL_BITS);
    localparam int NWORDS    = chain_nwords(CHAIN_LEN, WORD_W);
    localparam int BCW       = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int WCW       = (NWORDS > 0) ? $clog2(NWORDS + 1) : 1;
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_W - 1);
    localparam logic [WCW-1:0] WORDS_ALL = WCW'(NWORDS);

    if (!chain_cfg_ok(CHAIN_LEN, WORD_W)) begin : g_cfg_check
        $error("cfg_chain_loader: NUM_CELLS*CELL_BITS must be a non-zero multiple of WORD_W, WORD_W >= 2");
    end

    chain_state_e      state_q, state_d;
    logic [BCW-1:0]    bit_cnt_q;
    logic [WCW-1:0]    word_cnt_q;
    logic              full_q;
    logic [WORD_W-1:0] m_data_q;
    logic              m_valid_q;
    logic              aborted_q;

    logic              in_wr, in_rd, op_start, op_abort;
    logic              words_left, bit_at_last;
    logic              s_ready_c, chain_en_c, wr_accept;
    logic              word_end, wr_finish, rd_finish;
    logic              ser_out, ser_in;
    logic [WORD_W-1:0] par_next;

    assign in_wr       = (state_q == ST_WR);
    assign in_rd       = (state_q == ST_RD);
    assign op_start    = (state_q == ST_IDLE) && start;
    assign op_abort    = (in_wr || in_rd) && abort;
    assign words_left  = (word_cnt_q != WORDS_ALL);
    assign bit_at_last = (bit_cnt_q == BIT_LAST);

    // Both streams use strict valid/ready: a word moves on a cycle where valid
    // and ready are both high; valid never waits on ready, and the sender holds
    // data stable while valid is high and ready is low.
    assign s_ready_c  = in_wr && !abort && words_left && (!full_q || bit_at_last);
    assign wr_accept  = s_valid && s_ready_c;

    always_comb begin
        chain_en_c = 1'b0;
        if (in_wr) begin
            chain_en_c = full_q && !abort;
        end else if (in_rd) begin
            chain_en_c = !abort && words_left && !(m_valid_q && !m_ready);
        end
    end

    assign wr_finish = in_wr && word_end && !words_left;
    assign rd_finish = in_rd && !abort && !words_left && m_valid_q && m_ready;
    assign ser_in    = in_rd ? chain_din : 1'b0;

    cfg_word_serdes #(
        .WORD_W    (WORD_W),
        .MSB_FIRST (MSB_FIRST),
        .BCW       (BCW)
    ) u_serdes (
        .clk       (prog_clk),
        .rst       (prog_rst),
        .clr       (op_start || op_abort),
        .load      (wr_accept),
        .load_data (s_data),
        .shift     (chain_en_c),
        .ser_in    (ser_in),
        .bit_cnt   (bit_cnt_q),
        .ser_out   (ser_out),
        .par_next  (par_next),
        .last_bit  (word_end)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (mode == MODE_WR) ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (wr_finish) begin
                    state_d = ST_FIN;
                end
            end
            ST_RD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rd_finish) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            full_q     <= 1'b0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aborted_q <= op_abort;
            if (op_start || op_abort) begin
                bit_cnt_q  <= '0;
                word_cnt_q <= '0;
                full_q     <= 1'b0;
                m_valid_q  <= 1'b0;
            end else begin
                if (chain_en_c) begin
                    bit_cnt_q <= bit_at_last ? '0 : bit_cnt_q + BCW'(1);
                end
                if (in_wr) begin
                    if (wr_accept) begin
                        full_q     <= 1'b1;
                        word_cnt_q <= word_cnt_q + WCW'(1);
                    end else if (word_end) begin
                        full_q <= 1'b0;
                    end
                end
                // A completed capture may replace a word being consumed this cycle.
                if (in_rd) begin
                    if (word_end) begin
                        m_data_q   <= par_next;
                        m_valid_q  <= 1'b1;
                        word_cnt_q <= word_cnt_q + WCW'(1);
                    end else if (m_valid_q && m_ready) begin
                        m_valid_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign s_ready    = s_ready_c;
    assign chain_en   = chain_en_c;
    assign chain_dout = in_wr ? ser_out : (in_rd ? chain_din : 1'b0);
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign busy       = in_wr || in_rd;
    assign done       = (state_q == ST_FIN);
    assign aborted    = aborted_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: two instances (LSB-first and MSB-first)
// share stimulus, each feeding its own 16-bit chain model.
module tb_cfg_chain_loader;

  logic       clk = 1'b0;
  logic       prog_rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       abort = 1'b0;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] s_data = 8'h00;

  logic       s_ready0, m_valid0, chain_dout0, chain_en0, chain_din0, busy0, done0, aborted0;
  logic       s_ready1, m_valid1, chain_dout1, chain_en1, chain_din1, busy1, done1, aborted1;
  logic [7:0] m_data0, m_data1;
  logic [1:0] state0, state1;

  logic [15:0] chain0 = 16'h0000;
  logic [15:0] chain1 = 16'h0000;

  logic       exp_bits0[$];
  logic       exp_bits1[$];
  logic [7:0] exp_w0[$];
  logic [7:0] exp_w1[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int shifts0 = 0, dones0 = 0, aborts0 = 0;
  int run0 = 0, last_run0 = 0, gap0 = 0, last_gap0 = 0;
  bit chk_wr = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  cfg_chain_loader #(.NUM_CELLS(2), .CELL_BITS(8), .WORD_W(8), .MSB_FIRST(1'b0)) dut0 (
    .prog_clk(clk), .prog_rst(prog_rst), .start(start), .mode(mode), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready0),
    .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready),
    .chain_dout(chain_dout0), .chain_en(chain_en0), .chain_din(chain_din0),
    .busy(busy0), .done(done0), .aborted(aborted0), .state_dbg(state0)
  );

  cfg_chain_loader #(.NUM_CELLS(2), .CELL_BITS(8), .WORD_W(8), .MSB_FIRST(1'b1)) dut1 (
    .prog_clk(clk), .prog_rst(prog_rst), .start(start), .mode(mode), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1),
    .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready),
    .chain_dout(chain_dout1), .chain_en(chain_en1), .chain_din(chain_din1),
    .busy(busy1), .done(done1), .aborted(aborted1), .state_dbg(state1)
  );

  // Chain models: first bit shifted in ends up in bit 0 after 16 shifts.
  assign chain_din0 = chain0[0];
  assign chain_din1 = chain1[0];
  always @(posedge clk) if (chain_en0) chain0 <= {chain_dout0, chain0[15:1]};
  always @(posedge clk) if (chain_en1) chain1 <= {chain_dout1, chain1[15:1]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chain_en0) begin
      shifts0++;
      run0++;
      if (gap0 > 0) begin
        last_gap0 = gap0;
        gap0 = 0;
      end
    end else begin
      if (run0 > 0) begin
        last_run0 = run0;
        run0 = 0;
      end
      if (busy0) gap0++;
      else gap0 = 0;
    end
    if (done0) dones0++;
    if (aborted0) aborts0++;
    if (chk_wr && chain_en0) begin
      if (exp_bits0.size() > 0) check("dout0", chain_dout0, exp_bits0.pop_front());
      else check("extra_shift0", chain_en0, 0);
    end
    if (chk_wr && chain_en1) begin
      if (exp_bits1.size() > 0) check("dout1", chain_dout1, exp_bits1.pop_front());
      else check("extra_shift1", chain_en1, 0);
    end
    if (m_valid0) begin
      if (exp_w0.size() == 0) check("extra_word0", m_valid0, 0);
      else if (m_ready) check("m_data0", m_data0, exp_w0.pop_front());
      else begin
        check("m_hold0", m_data0, exp_w0[0]);
        check("stall_en0", chain_en0, 0);
      end
    end
    if (m_valid1) begin
      if (exp_w1.size() == 0) check("extra_word1", m_valid1, 0);
      else if (m_ready) check("m_data1", m_data1, exp_w1.pop_front());
      else check("m_hold1", m_data1, exp_w1[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      exp_bits0.push_back(w[i]);
      exp_bits1.push_back(w[7-i]);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    exp_w0.push_back(w);
    exp_w1.push_back(w);
  endtask

  task automatic start_op(input logic m);
    mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d);
    int n;
    n = 0;
    s_data = d;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("s_ready_timeout", s_ready0, 1);
    tick();
  endtask

  task automatic wait_done(output int at);
    int n;
    n = 0;
    while (done0 !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("done_seen", done0, 1);
    at = cyc;
  endtask

  task automatic wait_shifts(input int base, input int count);
    int n;
    n = 0;
    while ((shifts0 - base) < count && n < 100) begin
      tick();
      n++;
    end
    check("shift_wait", (shifts0 - base) >= count, 1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] b);
    int t;
    push_bits(a);
    push_bits(b);
    chk_wr = 1'b1;
    start_op(1'b0);
    send_word(a);
    send_word(b);
    s_valid = 1'b0;
    wait_done(t);
    tick();
    chk_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_s, base_d, base_a, t0, t1, n;

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_aborted", aborted0, 0);
    check("rst_chain_en", chain_en0, 0);
    check("rst_s_ready", s_ready0, 0);
    check("rst_m_valid", m_valid0, 0);
    check("rst_m_data", m_data0, 8'h00);
    check("rst_chain_dout", chain_dout0, 0);
    check("rst_state", state0, 2'd0);
    prog_rst = 1'b0;
    m_ready = 1'b1;
    tick();

    // Continuous write 0xA5, 0x3C with latency and done timing
    push_bits(8'hA5);
    push_bits(8'h3C);
    chk_wr = 1'b1;
    base_s = shifts0;
    base_d = dones0;
    s_data = 8'hA5;
    s_valid = 1'b1;
    t0 = cyc;
    start_op(1'b0);
    check("wr_c1_chain_en", chain_en0, 0);
    check("wr_c1_busy", busy0, 1);
    send_word(8'hA5);
    check("wr_c2_chain_en", chain_en0, 1);
    send_word(8'h3C);
    s_valid = 1'b0;
    wait_done(t1);
    check("wr_done_latency", t1 - t0, 18);
    tick();
    check("wr_done_pulse", done0, 0);
    chk_wr = 1'b0;
    check("wr_shifts", shifts0 - base_s, 16);
    check("wr_run", last_run0, 16);
    check("wr_dones", dones0 - base_d, 1);
    check("wr_model0", chain0, 16'h3CA5);
    check("wr_model1", chain1, 16'h3CA5);
    check("wr_bits_left", exp_bits0.size(), 0);

    // Readback with consumer always ready
    push_word(8'hA5);
    push_word(8'h3C);
    base_s = shifts0;
    start_op(1'b1);
    wait_done(t1);
    tick();
    check("rd_shifts", shifts0 - base_s, 16);
    check("rd_run", last_run0, 16);
    check("rd_model0", chain0, 16'h3CA5);
    check("rd_words_left0", exp_w0.size(), 0);
    check("rd_words_left1", exp_w1.size(), 0);

    // Readback with a 5-cycle stall after the first word
    m_ready = 1'b0;
    push_word(8'hA5);
    push_word(8'h3C);
    base_s = shifts0;
    start_op(1'b1);
    n = 0;
    @(negedge clk);
    while (!m_valid0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_m_valid", m_valid0, 1);
    repeat (5) tick();
    m_ready = 1'b1;
    wait_done(t1);
    tick();
    check("bp_shifts", shifts0 - base_s, 16);
    check("bp_stall_len", last_gap0, 5);
    check("bp_model0", chain0, 16'h3CA5);
    check("bp_words_left", exp_w0.size(), 0);

    // Underrun: 0xFF, four idle cycles, then 0x00
    push_bits(8'hFF);
    push_bits(8'h00);
    chk_wr = 1'b1;
    base_s = shifts0;
    base_d = dones0;
    start_op(1'b0);
    send_word(8'hFF);
    s_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (chain_en0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) tick();
    send_word(8'h00);
    s_valid = 1'b0;
    wait_done(t1);
    tick();
    chk_wr = 1'b0;
    check("ur_shifts", shifts0 - base_s, 16);
    check("ur_gap", last_gap0, 4);
    check("ur_run", last_run0, 8);
    check("ur_dones", dones0 - base_d, 1);
    check("ur_model0", chain0, 16'h00FF);
    check("ur_model1", chain1, 16'h00FF);

    // Abort after 5 shifts of a write
    base_s = shifts0;
    base_d = dones0;
    base_a = aborts0;
    s_data = 8'h5A;
    s_valid = 1'b1;
    start_op(1'b0);
    wait_shifts(base_s, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    s_valid = 1'b0;
    check("ab_chain_en", chain_en0, 0);
    check("ab_busy", busy0, 0);
    check("ab_aborted", aborted0, 1);
    check("ab_s_ready", s_ready0, 0);
    check("ab_m_valid", m_valid0, 0);
    check("ab_state", state0, 2'd0);
    tick();
    check("ab_aborted_pulse", aborted0, 0);
    repeat (3) tick();
    check("ab_no_done", dones0 - base_d, 0);
    check("ab_count", aborts0 - base_a, 1);
    check("ab_shifts", shifts0 - base_s, 5);
    start_op(1'b0);
    check("ab_restart_busy", busy0, 1);

    // Same interruption via prog_rst
    base_s = shifts0;
    base_d = dones0;
    base_a = aborts0;
    s_data = 8'h5A;
    s_valid = 1'b1;
    wait_shifts(base_s, 5);
    prog_rst = 1'b1;
    tick();
    prog_rst = 1'b0;
    s_valid = 1'b0;
    check("rs_chain_en", chain_en0, 0);
    check("rs_busy", busy0, 0);
    check("rs_aborted", aborted0, 0);
    check("rs_state", state0, 2'd0);
    repeat (3) tick();
    check("rs_no_done", dones0 - base_d, 0);
    check("rs_no_abort", aborts0 - base_a, 0);

    // Recovery: a full write after the interruptions
    base_d = dones0;
    do_write(8'hC3, 8'h81);
    check("rc_dones", dones0 - base_d, 1);
    check("rc_model0", chain0, 16'h81C3);
    check("rc_model1", chain1, 16'h81C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Parametrised configuration-chain controller for one fabric row of NUM_CELLS connection/logic cells. Each cell holds CELL_BITS configuration bits, daisy-chained prog_in to prog_out.
- Write mode: accepts bitstream words over a valid/ready stream and serialises them onto the chain.
- Readback mode: recirculates the chain non-destructively and returns its contents as words.
- Replaces ad-hoc per-row bit-banging. One instance sits at the head of each row, even or odd.

Parameters:
- NUM_CELLS, 8, number of cells in the chain.
- CELL_BITS, 32, configuration bits per cell.
- WORD_W, 8, stream word width. NUM_CELLS*CELL_BITS must be a multiple of WORD_W; elaboration error otherwise.
- MSB_FIRST, 0, 0 = bit 0 of each word is shifted and captured first; 1 = bit WORD_W-1 first.

Ports:
- prog_clk, in, 1, sole clock.
- prog_rst, in, 1, reset. Synchronous, active-high.
- start, in, 1, begin an operation. Sampled only in IDLE.
- mode, in, 1, 0 = write, 1 = readback. Sampled with start.
- abort, in, 1, synchronous abort of the current operation.
- s_data, in, WORD_W, write word.
- s_valid, in, 1, write word valid.
- s_ready, out, 1, write word accepted when s_valid && s_ready.
- m_data, out, WORD_W, readback word.
- m_valid, out, 1, readback word valid.
- m_ready, in, 1, readback consumer ready.
- chain_dout, out, 1, drives prog_in of the first cell.
- chain_en, out, 1, drives prog_en. Chain shifts one bit on each prog_clk edge where it is high.
- chain_din, in, 1, from prog_out of the last cell (registered in the cell).
- busy, out, 1, high in WR or RD.
- done, out, 1, one-cycle pulse on completion.
- aborted, out, 1, one-cycle pulse on abort.

Behaviour:
- Constants: CHAIN_LEN = NUM_CELLS*CELL_BITS; NWORDS = CHAIN_LEN/WORD_W.
- Reset values: all outputs 0, FSM = IDLE, bit/word counters 0, shift and capture registers 0.
- FSM states: IDLE, WR, RD, FIN.
  - IDLE -> WR on start && !mode; IDLE -> RD on start && mode.
  - WR or RD -> FIN after the CHAIN_LEN-th enabled shift.
  - FIN: done = 1 for exactly one cycle, then IDLE.
  - start outside IDLE is ignored.
- WR:
  - WORD_W-bit shift register plus a "full" flag.
  - s_ready = !full || (bit_cnt == WORD_W-1 && chain_en), so back-to-back words produce no bubble.
  - s_ready is forced 0 once NWORDS words have been accepted.
  - chain_en = full. chain_dout = LSB (MSB_FIRST=0) or MSB of the shift register.
  - Underrun (no word available): chain_en = 0 and the chain holds. This is not an error.
- RD:
  - chain_dout = chain_din (combinational recirculate), so chain contents are restored after CHAIN_LEN shifts.
  - chain_en = !(m_valid && !m_ready).
  - Each enabled cycle, chain_din is captured into the capture register in the bit order set by MSB_FIRST.
  - After WORD_W captures, the word moves to m_data and m_valid is set. The transfer may coincide with m_ready consuming the previous word.
  - m_valid holds until m_ready; m_data is stable while m_valid && !m_ready.
  - FIN is entered only after the last word is consumed.
- abort in WR or RD:
  - Next cycle: FSM = IDLE, chain_en = 0, s_ready = 0, m_valid = 0, aborted = 1 for one cycle, no done.
  - Chain contents are then undefined.
  - abort in IDLE or FIN is ignored, and FIN still pulses done.
- prog_rst mid-operation behaves identically to abort, except aborted stays 0.
- start and abort asserted together in IDLE: start wins.
- Counters: bit_cnt is clog2(WORD_W) wide and wraps at WORD_W-1; word_cnt is clog2(NWORDS+1) wide.
- Latency: first chain_en is 2 cycles after start, given s_valid is already high. Full write takes CHAIN_LEN+2 cycles with a continuous stream; done follows on the next cycle.

Decomposition:
- Shared package cfg_chain_pkg:
  - FSM state enum.
  - localparam function computing CHAIN_LEN/NWORDS and the divisibility check.
  - mode encodings MODE_WR = 0, MODE_RD = 1.
- Sub-module cfg_word_serdes: one WORD_W shift register handling both serialise (WR) and capture (RD), with MSB_FIRST ordering, a load strobe and a last-bit flag.
- The top level owns the FSM, counters and handshakes.

Test Plan:
- Common setup: NUM_CELLS=2, CELL_BITS=8, WORD_W=8, MSB_FIRST=0. The bench models the chain as a 16-bit shift register.
- Write, continuous stream: start, mode = 0; words 0xA5 then 0x3C with s_valid held -> chain_dout sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. chain_en high for 16 consecutive cycles. done pulses once. Model holds 0x3CA5.
- Readback after the write: start, mode = 1, m_ready = 1 -> m_data 0xA5 then 0x3C. chain_en high for 16 cycles. Model still holds 0x3CA5.
- Backpressure: readback with m_ready low for 5 cycles after the first m_valid -> chain_en low during the stall, m_data stable at 0xA5, total shifts still exactly 16.
- Underrun: 0xFF sent, s_valid low for 4 cycles, then 0x00 -> chain_en low for exactly those 4 cycles, 16 total shifts, one done.
- Abort: abort after 5 shifts of a write -> next cycle chain_en = 0, busy = 0, aborted = 1, no done. A following start is accepted. Repeat with prog_rst instead -> same, aborted = 0.
- MSB_FIRST=1 variant: write 0xA5 -> first 8 chain_dout bits 1,0,1,0,0,1,0,1, read back as 0xA5.
